// File: rtl/config_source_arbiter_if.sv
// Source-side and config-side signal bundle of the configuration source arbiter.
// master drives the four write sources and the controls; slave is the arbiter.
interface config_source_arbiter_if;
  logic [31:0] SelfWriteData;
  logic        SelfWriteStrobe;
  logic [31:0] UARTWriteData;
  logic        UARTWriteStrobe;
  logic [31:0] BitBangWriteData;
  logic        BitBangWriteStrobe;
  logic [31:0] JTAGWriteData;
  logic        JTAGWriteStrobe;
  logic        JTAGActive;
  logic        ClearDrop;
  logic [31:0] ConfigWriteData;
  logic        ConfigWriteStrobe;
  logic [1:0]  Owner;
  logic        OwnerValid;
  logic [3:0]  DropFlags;

  modport master (
    output SelfWriteData, SelfWriteStrobe, UARTWriteData, UARTWriteStrobe,
           BitBangWriteData, BitBangWriteStrobe, JTAGWriteData, JTAGWriteStrobe,
           JTAGActive, ClearDrop,
    input  ConfigWriteData, ConfigWriteStrobe, Owner, OwnerValid, DropFlags
  );

  modport slave (
    input  SelfWriteData, SelfWriteStrobe, UARTWriteData, UARTWriteStrobe,
           BitBangWriteData, BitBangWriteStrobe, JTAGWriteData, JTAGWriteStrobe,
           JTAGActive, ClearDrop,
    output ConfigWriteData, ConfigWriteStrobe, Owner, OwnerValid, DropFlags
  );
endinterface

// File: rtl/config_source_arbiter.sv
// Session-based arbiter merging CPU/UART/BitBang/JTAG config writes into one
// registered word stream; JTAG can pre-empt, non-owner writes set sticky drop flags.
module config_source_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                   CLK,
  input  logic                   resetn,
  config_source_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_OWNED     = 2'd1,
    ST_JTAG_LOCK = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]       ID_CPU       = 2'd0;
  localparam logic [1:0]       ID_UART      = 2'd1;
  localparam logic [1:0]       ID_BITBANG   = 2'd2;
  localparam logic [1:0]       ID_JTAG      = 2'd3;

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [31:0]      data_q,   data_d;
  logic             strobe_q, strobe_d;
  logic [1:0]       owner_q,  owner_d;
  logic             valid_q,  valid_d;
  logic [3:0]       drop_q,   drop_d;

  logic [3:0]  req_s;
  logic [31:0] src_data_s [4];
  logic [3:0]  owner_oh_s;
  logic        preempt_s;
  logic        expire_s;
  logic        fwd_en_s;
  logic [1:0]  fwd_id_s;
  logic [1:0]  idle_win_s;
  logic [3:0]  drop_set_s;

  // Request vector and data indexed by source id.
  always_comb begin
    req_s         = {bus.JTAGWriteStrobe, bus.BitBangWriteStrobe,
                     bus.UARTWriteStrobe, bus.SelfWriteStrobe};
    src_data_s[0] = bus.SelfWriteData;
    src_data_s[1] = bus.UARTWriteData;
    src_data_s[2] = bus.BitBangWriteData;
    src_data_s[3] = bus.JTAGWriteData;
    owner_oh_s    = 4'b0001 << owner_q;
    preempt_s     = bus.JTAGActive && (state_q != ST_JTAG_LOCK);
    expire_s      = !req_s[owner_q] && (cnt_q == CNT_W'(1));
    if (req_s[3]) begin
      idle_win_s = ID_JTAG;
    end else if (req_s[0]) begin
      idle_win_s = ID_CPU;
    end else if (req_s[1]) begin
      idle_win_s = ID_UART;
    end else begin
      idle_win_s = ID_BITBANG;
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      data_q   <= 32'h0000_0000;
      strobe_q <= 1'b0;
      owner_q  <= 2'd0;
      valid_q  <= 1'b0;
      drop_q   <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      owner_q  <= owner_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  end

  // Next state and session timeout counter; reload beats decrement, 0 saturates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (preempt_s) begin
      state_d = ST_JTAG_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_s) begin
            state_d = ST_OWNED;
            cnt_d   = TIMEOUT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_OWNED: begin
          if (req_s[owner_q]) begin
            cnt_d = TIMEOUT_LOAD;
          end else begin
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
          end
          if (expire_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_OWNED;
          end
        end
        ST_JTAG_LOCK: begin
          if (!bus.JTAGActive) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_JTAG_LOCK;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Forwarding, ownership and drop-flag updates for the current cycle.
  always_comb begin
    fwd_en_s   = 1'b0;
    fwd_id_s   = owner_q;
    owner_d    = owner_q;
    valid_d    = valid_q;
    drop_set_s = 4'b0000;
    if (preempt_s) begin
      owner_d    = ID_JTAG;
      valid_d    = 1'b1;
      fwd_en_s   = req_s[3];
      fwd_id_s   = ID_JTAG;
      drop_set_s = req_s & 4'b0111;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_s) begin
            fwd_en_s   = 1'b1;
            fwd_id_s   = idle_win_s;
            owner_d    = idle_win_s;
            valid_d    = 1'b1;
            drop_set_s = req_s & ~(4'b0001 << idle_win_s);
          end else begin
            valid_d = 1'b0;
          end
        end
        ST_OWNED: begin
          fwd_en_s   = req_s[owner_q];
          drop_set_s = req_s & ~owner_oh_s;
          if (expire_s) begin
            valid_d = 1'b0;
          end else begin
            valid_d = 1'b1;
          end
        end
        ST_JTAG_LOCK: begin
          fwd_en_s   = req_s[3];
          fwd_id_s   = ID_JTAG;
          drop_set_s = req_s & 4'b0111;
          valid_d    = bus.JTAGActive;
        end
        default: begin
          valid_d = 1'b0;
        end
      endcase
    end
    strobe_d = fwd_en_s;
    if (fwd_en_s) begin
      data_d = src_data_s[fwd_id_s];
    end else begin
      data_d = data_q;
    end
    // A new drop wins over ClearDrop only for its own bit.
    if (bus.ClearDrop) begin
      drop_d = drop_set_s;
    end else begin
      drop_d = drop_q | drop_set_s;
    end
  end

  assign bus.ConfigWriteData   = data_q;
  assign bus.ConfigWriteStrobe = strobe_q;
  assign bus.Owner             = owner_q;
  assign bus.OwnerValid        = valid_q;
  assign bus.DropFlags         = drop_q;

endmodule

// File: tb/tb_config_source_arbiter.sv
// Directed plus randomized bench for config_source_arbiter against a
// cycle-indexed session model (ownership expires at last-word edge + timeout).
module tb_config_source_arbiter;
  localparam int T = 4;

  logic clk;
  logic resetn;
  config_source_arbiter_if bus ();

  config_source_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .CLK    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // model state
  int          n = 0;
  bit          m_lock = 0;
  bit          m_valid = 0;
  int          m_owner = 0;
  int          m_rel = 0;
  bit          m_stb = 0;
  logic [31:0] m_data = 32'h0;
  logic [3:0]  m_drop = 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic [3:0] stb, input logic [31:0] dat, input bit jact, input bit clr);
    bus.SelfWriteStrobe    = stb[0];
    bus.UARTWriteStrobe    = stb[1];
    bus.BitBangWriteStrobe = stb[2];
    bus.JTAGWriteStrobe    = stb[3];
    bus.SelfWriteData      = dat;
    bus.UARTWriteData      = dat + 32'h1000_0000;
    bus.BitBangWriteData   = dat + 32'h2000_0000;
    bus.JTAGWriteData      = dat + 32'h3000_0000;
    bus.JTAGActive         = jact;
    bus.ClearDrop          = clr;
  endtask

  task automatic cycle();
    logic [3:0]  req;
    logic [31:0] d [4];
    logic [3:0]  dset;
    bit          jact, clr, rst, found;
    int          w;
    int          order [4];
    order = '{3, 0, 1, 2};
    req  = {bus.JTAGWriteStrobe, bus.BitBangWriteStrobe, bus.UARTWriteStrobe, bus.SelfWriteStrobe};
    d[0] = bus.SelfWriteData;    d[1] = bus.UARTWriteData;
    d[2] = bus.BitBangWriteData; d[3] = bus.JTAGWriteData;
    jact = bus.JTAGActive; clr = bus.ClearDrop; rst = !resetn;
    @(posedge clk);
    n++;
    dset  = 4'h0;
    m_stb = 0;
    if (rst) begin
      m_lock = 0; m_valid = 0; m_owner = 0; m_data = 32'h0; m_drop = 4'h0;
    end else begin
      if (jact && !m_lock) begin
        m_lock = 1; m_valid = 1; m_owner = 3;
        if (req[3]) begin m_stb = 1; m_data = d[3]; end
        dset = req & 4'b0111;
      end else if (m_lock) begin
        if (req[3]) begin m_stb = 1; m_data = d[3]; end
        dset = req & 4'b0111;
        if (!jact) begin m_lock = 0; m_valid = 0; end
      end else if (!m_valid) begin
        found = 0; w = 0;
        foreach (order[k]) if (!found && req[order[k]]) begin found = 1; w = order[k]; end
        if (found) begin
          m_valid = 1; m_owner = w; m_stb = 1; m_data = d[w]; m_rel = n + T;
          for (int i = 0; i < 4; i++) if (i != w && req[i]) dset[i] = 1'b1;
        end
      end else begin
        for (int i = 0; i < 4; i++) if (i != m_owner && req[i]) dset[i] = 1'b1;
        if (req[m_owner]) begin
          m_stb = 1; m_data = d[m_owner]; m_rel = n + T;
        end else if (n == m_rel) begin
          m_valid = 0;
        end
      end
      m_drop = (clr ? 4'h0 : m_drop) | dset;
    end
    #1;
    chk("strobe", {31'h0, bus.ConfigWriteStrobe}, {31'h0, m_stb});
    chk("owner_valid", {31'h0, bus.OwnerValid}, {31'h0, m_valid});
    chk("owner", {30'h0, bus.Owner}, 32'(m_owner));
    chk("drop_flags", {28'h0, bus.DropFlags}, {28'h0, m_drop});
    if (m_stb || rst) chk("data", bus.ConfigWriteData, m_data);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      drive(4'b0000, 32'h0, 1'b0, 1'b0);
      cycle();
    end
  endtask

  initial begin
    resetn = 1'b1;
    drive(4'b0000, 32'h0, 1'b0, 1'b0);
    #2;
    // reset with toggling strobes
    resetn = 1'b0;
    drive(4'b1111, 32'h1234_5678, 1'b0, 1'b0); cycle();
    drive(4'b0101, 32'h8765_4321, 1'b0, 1'b0); cycle();
    chk("reset_outputs", {bus.ConfigWriteStrobe, bus.OwnerValid, bus.Owner, bus.DropFlags}, 32'h0);
    chk("reset_data", bus.ConfigWriteData, 32'h0);
    resetn = 1'b1;
    drive(4'b0001, 32'hFAB0_FAB1, 1'b0, 1'b0); cycle();
    chk("first_word", bus.ConfigWriteData, 32'hFAB0_FAB1);
    chk("first_owner", {bus.ConfigWriteStrobe, bus.OwnerValid, bus.Owner}, {28'h0, 4'b1100});
    idle(T + 1);

    // priority and drops
    drive(4'b0111, 32'h0000_0A0A, 1'b0, 1'b0); cycle();
    chk("prio_data", bus.ConfigWriteData, 32'h0000_0A0A);
    chk("prio_drops", {28'h0, bus.DropFlags}, 32'h6);
    drive(4'b0000, 32'h0, 1'b0, 1'b1); cycle();
    chk("clear_drops", {28'h0, bus.DropFlags}, 32'h0);
    idle(T + 1);

    // timeout boundary: owner strobe just before expiry keeps ownership
    drive(4'b0010, 32'h0000_0001, 1'b0, 1'b0); cycle();
    idle(T - 1);
    drive(4'b0010, 32'h0000_0002, 1'b0, 1'b0); cycle();
    chk("keep_owner", {bus.ConfigWriteStrobe, bus.OwnerValid, bus.Owner}, {28'h0, 4'b1101});
    idle(T - 1);
    drive(4'b0100, 32'h0000_0003, 1'b0, 1'b0); cycle();
    chk("late_drop", {bus.OwnerValid, bus.DropFlags[2]}, 32'h1);
    drive(4'b0100, 32'h0000_0004, 1'b0, 1'b0); cycle();
    chk("bb_grant", {bus.ConfigWriteStrobe, bus.OwnerValid, bus.Owner}, {28'h0, 4'b1110});
    drive(4'b0000, 32'h0, 1'b0, 1'b1); cycle();
    idle(T + 1);

    // pre-emption of a UART stream
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010, 32'(i + 16), 1'b0, 1'b0); cycle();
    end
    drive(4'b1010, 32'h0000_0055, 1'b1, 1'b0); cycle();
    chk("preempt", {bus.ConfigWriteStrobe, bus.OwnerValid, bus.Owner, bus.DropFlags}, {24'h0, 8'b1111_0010});
    chk("preempt_data", bus.ConfigWriteData, 32'h3000_0055);
    drive(4'b0001, 32'h0, 1'b1, 1'b0); cycle();
    drive(4'b1000, 32'h66, 1'b1, 1'b1); cycle();
    drive(4'b0000, 32'h0, 1'b0, 1'b0); cycle();
    chk("lock_exit", {31'h0, bus.OwnerValid}, 32'h0);

    // full rate
    for (int i = 1; i <= 8; i++) begin
      drive(4'b0001, 32'(i), 1'b0, 1'b0); cycle();
      chk("full_rate", {bus.ConfigWriteStrobe, bus.ConfigWriteData[30:0]}, {1'b1, 31'(i)});
    end
    idle(T + 1);

    // reset mid-session, JTAGActive low then high
    drive(4'b0000, 32'h0, 1'b1, 1'b0); cycle();
    resetn = 1'b0; drive(4'b0000, 32'h0, 1'b0, 1'b0); cycle();
    chk("midreset", {bus.OwnerValid, bus.Owner, bus.ConfigWriteStrobe}, 32'h0);
    resetn = 1'b1; idle(2);
    drive(4'b0000, 32'h0, 1'b1, 1'b0); cycle();
    resetn = 1'b0; cycle();
    resetn = 1'b1; cycle();
    chk("relock", {bus.OwnerValid, bus.Owner}, 32'h7);
    drive(4'b0000, 32'h0, 1'b0, 1'b0); cycle();

    // randomized phase
    begin
      bit jact = 0;
      for (int i = 0; i < 400; i++) begin
        logic [3:0] stb;
        for (int b = 0; b < 4; b++) stb[b] = ($urandom_range(99) < 30);
        if ($urandom_range(19) == 0) jact = !jact;
        resetn = ($urandom_range(99) != 0);
        drive(stb, $urandom, jact, $urandom_range(15) == 0);
        cycle();
        if ($urandom_range(9) == 0) begin
          resetn = 1'b1;
          idle($urandom_range(T + 2));
        end
      end
    end
    resetn = 1'b1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/config_source_arbiter.md
# config_source_arbiter

Arbitrates the four configuration write sources of the eFPGA (CPU self-write, UART, BitBang, JTAG) onto the single 32-bit configuration word stream that feeds the frame/config FSM. Ownership is session-based, so bitstreams from different sources never interleave. JTAG can pre-empt any other owner while `JTAGActive` is high. Non-owner writes are dropped and recorded in sticky flags. All inputs are already in the `CLK` domain; JTAG data and strobe are synchronized upstream.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: idle cycles after the last owner write before ownership is released; legal range 1 .. 2^`CNT_W`-1.
- `CNT_W`, 16: timeout counter width.

Ports:
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `resetn`  in  1  reset, synchronous and active-low.
- `SelfWriteData` / `SelfWriteStrobe`  in  32 / 1  CPU source (id 0).
- `UARTWriteData` / `UARTWriteStrobe`  in  32 / 1  UART source (id 1).
- `BitBangWriteData` / `BitBangWriteStrobe`  in  32 / 1  BitBang source (id 2).
- `JTAGWriteData` / `JTAGWriteStrobe`  in  32 / 1  JTAG source (id 3).
- `JTAGActive`  in  1  level input; JTAG session lock request.
- `ClearDrop`  in  1  one-cycle pulse; clears `DropFlags`.
- `ConfigWriteData`  out  32  forwarded word, registered.
- `ConfigWriteStrobe`  out  1  one-cycle write pulse, registered.
- `Owner`  out  2  current owner id (0 to 3).
- `OwnerValid`  out  1  high when a source owns the port.
- `DropFlags`  out  4  sticky per-source drop indicators; bit index = source id.

## Operation
- States: IDLE, OWNED, JTAG_LOCK.
- Reset (`resetn`=0 at an edge): state IDLE; `ConfigWriteData`=0, `ConfigWriteStrobe`=0, `Owner`=0, `OwnerValid`=0, `DropFlags`=0, counter=0. Reset applied mid-session discards ownership. No strobe is emitted in the reset cycle.
- The strobes are one-cycle pulses per word. Each cycle is evaluated in this order:
  1. **Pre-emption.** If `JTAGActive`=1 and the state is not JTAG_LOCK, go to JTAG_LOCK with `Owner`=3. A `JTAGWriteStrobe` in that same cycle is forwarded. Every other strobe in that cycle is dropped, including one from the pre-empted owner.
  2. **JTAG_LOCK.** Only JTAG strobes are forwarded. When `JTAGActive`=0, go to IDLE at the next edge. A JTAG strobe in that cycle is still forwarded. The timeout counter is unused in this state.
  3. **IDLE.** Among the asserted strobes, grant the highest-priority source (JTAG > CPU > UART > BitBang). Forward its word, go to OWNED, and load counter = `TIMEOUT_CYCLES`. Lower-priority simultaneous strobes are dropped.
  4. **OWNED.**
     - Owner strobe: forward the word and reload the counter.
     - No owner strobe: decrement the counter. If the counter is 1 and there is no owner strobe, go to IDLE at that edge.
     - Non-owner strobes are always dropped.
- **Drop.** A dropped strobe sets `DropFlags[id]`. If `ClearDrop` and a new drop occur in the same cycle, the set wins for that bit and other bits clear.
- The counter is `CNT_W` bits wide and never wraps: it saturates at 0, and reload takes priority over decrement.
- `Owner` holds its last value while in IDLE; only `OwnerValid` falls.

## Timing
- Latency: a strobe accepted at edge t appears as `ConfigWriteData`/`ConfigWriteStrobe` for the cycle after edge t. Fixed latency is 1 cycle. Back-to-back words (a strobe every cycle) are forwarded at full rate.
- `Owner` and `OwnerValid` update at the same edge as the first forwarded word.
- Release: if the last owner word is accepted at edge t, `OwnerValid` falls at edge t+`TIMEOUT_CYCLES`.
  - An owner strobe in the cycle before that edge reloads the counter, so no release occurs.
  - A different source strobing in the cycle before that edge is dropped.
  - A different source strobing in any cycle after that edge is granted.
- JTAG pre-emption takes effect at the first edge where `JTAGActive`=1. JTAG_LOCK exits at the first edge where `JTAGActive`=0.
- `DropFlags` set at the edge following the dropped strobe.

## Test plan
- **Reset.** Assert `resetn`=0 for 2 cycles with all strobes toggling → all outputs 0; first `SelfWriteStrobe` with data 0xFAB0FAB1 after reset → strobe out 1 cycle later with 0xFAB0FAB1, `Owner`=0, `OwnerValid`=1.
- **Priority and drops.** From IDLE, assert CPU, UART and BitBang strobes in the same cycle → CPU word forwarded, `Owner`=0, `DropFlags`=4'b0110. Then pulse `ClearDrop` → `DropFlags`=0.
- **Timeout boundary.** Set `TIMEOUT_CYCLES`=4. UART owns with last word at edge t.
  - UART strobe at the cycle before t+4 → forwarded, still owner.
  - Repeat with no strobe: BitBang strobe before t+4 → dropped, `DropFlags[2]`=1.
  - BitBang strobe after t+4 → forwarded, `Owner`=2.
- **Pre-emption.** UART mid-stream. Raise `JTAGActive` together with a UART strobe and a JTAG strobe → JTAG word forwarded, UART dropped, `Owner`=3. Drop `JTAGActive` → `OwnerValid`=0 at the next edge.
- **Full rate.** CPU strobes 8 consecutive cycles with data 1..8 → 8 consecutive output strobes with 1..8 and no gaps.
- **Reset mid-session.** Pulse `resetn`=0 while in JTAG_LOCK with `JTAGActive`=0 → IDLE, outputs reset. With `JTAGActive` still 1 after reset → JTAG_LOCK at the first edge after reset.
